// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the LCD write arbiter
package lcd_pkg;

    localparam int LCD_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } lcd_state_e;

    localparam logic [7:0] LCD_CMD_FUNCTION_SET = 8'h38;
    localparam logic [7:0] LCD_CMD_DISPLAY_ON   = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR        = 8'h01;
    localparam logic [7:0] LCD_CHAR_NEWLINE     = 8'h0A;

endpackage

// File: rtl/lcd_rr_pick.sv
// rtl/lcd_rr_pick.sv - combinational round-robin selector starting after last_grant
module lcd_rr_pick
    import lcd_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               any_req,
    output logic [IDX_W-1:0]   grant_idx
);

    int                 pos;
    logic [IDX_W-1:0]   idx;

    // Scan farthest-first so the requester nearest after last_grant overwrites the rest.
    always_comb begin
        any_req   = |req;
        grant_idx = '0;
        pos       = 0;
        idx       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            pos = (int'(last_grant) + k) % NUM_REQ;
            idx = pos[IDX_W-1:0];
            if (req[idx]) begin
                grant_idx = idx;
            end
        end
    end

endmodule

// File: rtl/lcd_write_arbiter.sv
// rtl/lcd_write_arbiter.sv - round-robin arbiter sharing one LCD character writer
module lcd_write_arbiter
    import lcd_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = LCD_DATA_W,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_cd,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         lcd_data,
    output logic                      lcd_select_cd,
    output logic                      lcd_enable_writing,
    input  logic                      lcd_available,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lcd_state_e          state_q, state_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [NUM_REQ-1:0]  ack_q, ack_d, done_q, done_d;
    logic [DATA_W-1:0]   lcd_data_q, lcd_data_d;
    logic                cd_q, cd_d, en_q, en_d, busy_q, busy_d, terr_q, terr_d;
    logic                any_req, timeout_hit;
    logic [IDX_W-1:0]    grant_idx;

    lcd_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .any_req    (any_req),
        .grant_idx  (grant_idx)
    );

    // Saturating so a stuck writer can never wrap the counter back into range.
    assign cnt_inc     = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
    assign timeout_hit = (cnt_inc == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        ack_d        = '0;
        done_d       = '0;
        lcd_data_d   = lcd_data_q;
        cd_d         = cd_q;
        en_d         = en_q;
        busy_d       = busy_q;
        terr_d       = terr_q;
        case (state_q)
            ST_IDLE: begin
                if (lcd_available && any_req) begin
                    state_d          = ST_ISSUE;
                    lcd_data_d       = req_data[grant_idx*DATA_W +: DATA_W];
                    cd_d             = req_cd[grant_idx];
                    last_grant_d     = grant_idx;
                    ack_d[grant_idx] = 1'b1;
                    en_d             = 1'b1;
                    busy_d           = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
                cnt_d   = '0;
            end
            ST_WAIT_BUSY, ST_WAIT_DONE: begin
                if (state_q == ST_WAIT_BUSY && !lcd_available) begin
                    en_d    = 1'b0;
                    state_d = ST_WAIT_DONE;
                    cnt_d   = '0;
                end else if (state_q == ST_WAIT_DONE && lcd_available) begin
                    done_d[last_grant_q] = 1'b1;
                    busy_d               = 1'b0;
                    state_d              = ST_IDLE;
                end else if (timeout_hit) begin
                    en_d                 = 1'b0;
                    terr_d               = 1'b1;
                    done_d[last_grant_q] = 1'b1;
                    busy_d               = 1'b0;
                    state_d              = ST_IDLE;
                    cnt_d                = cnt_inc;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            cnt_q        <= '0;
            ack_q        <= '0;
            done_q       <= '0;
            lcd_data_q   <= '0;
            cd_q         <= 1'b0;
            en_q         <= 1'b0;
            busy_q       <= 1'b0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            lcd_data_q   <= lcd_data_d;
            cd_q         <= cd_d;
            en_q         <= en_d;
            busy_q       <= busy_d;
            terr_q       <= terr_d;
        end
    end

    assign ack                = ack_q;
    assign done               = done_q;
    assign lcd_data           = lcd_data_q;
    assign lcd_select_cd      = cd_q;
    assign lcd_enable_writing = en_q;
    assign busy               = busy_q;
    assign timeout_err        = terr_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb/tb_lcd_write_arbiter.sv - self-checking bench for lcd_write_arbiter
module tb_lcd_write_arbiter;

    localparam int NR = 2;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_cd;
    logic [NR-1:0]     ack, done;
    logic [DW-1:0]     lcd_data;
    logic              lcd_select_cd, lcd_enable_writing, lcd_available, busy, timeout_err;

    int n_cmp = 0;
    int n_mis = 0;
    int last_m;
    bit te_m;

    always #5 clk = ~clk;

    lcd_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk                (clk),
        .rst                (rst),
        .req                (req),
        .req_data           (req_data),
        .req_cd             (req_cd),
        .ack                (ack),
        .done               (done),
        .lcd_data           (lcd_data),
        .lcd_select_cd      (lcd_select_cd),
        .lcd_enable_writing (lcd_enable_writing),
        .lcd_available      (lcd_available),
        .busy               (busy),
        .timeout_err        (timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input logic [NR-1:0] r, input int last);
        logic [NR-1:0] rot;
        for (int k = 1; k <= NR; k++) begin
            rot = r >> ((last + k) % NR);
            if (rot[0]) return (last + k) % NR;
        end
        return 0;
    endfunction

    task automatic set_word(input int i);
        req_data[i*DW +: DW] = $urandom;
        req_cd[i]            = 1'($urandom_range(0, 1));
    endtask

    // One transaction: writer drops available after d cycles, restores it h cycles later;
    // hang keeps the writer available so the timeout must fire.
    task automatic run_txn(input int d, input int h, input bit hang, input bit drop, input int pulse_k);
        int            g, fall, fin;
        logic [DW-1:0] w;
        logic          c;
        logic [NR-1:0] oh, exp_done;
        g    = rr(req, last_m);
        w    = req_data[g*DW +: DW];
        c    = req_cd[g];
        oh   = NR'(1) << g;
        fall = hang ? TO : d + 1;
        fin  = hang ? TO : d + h + 1;
        tick();
        chk("ack_grant", ack, oh);
        chk("enable_at_ack", lcd_enable_writing, 1);
        chk("busy_at_ack", busy, 1);
        chk("data_latch", lcd_data, w);
        chk("cd_latch", lcd_select_cd, c);
        chk("done_at_ack", done, 0);
        last_m = g;
        if (drop) req = req & ~oh;
        else set_word(g);
        for (int k = 1; k <= fin; k++) begin
            tick();
            exp_done = (k == fin) ? oh : '0;
            if (k == fin) te_m = te_m | hang;
            chk("ack_quiet", ack, 0);
            chk("enable", lcd_enable_writing, (k < fall));
            chk("busy", busy, (k < fin));
            chk("done", done, exp_done);
            chk("data_hold", lcd_data, w);
            chk("cd_hold", lcd_select_cd, c);
            chk("timeout_err", timeout_err, te_m);
            if (pulse_k > 0 && k == pulse_k) req[1] = 1'b1;
            if (pulse_k > 0 && k == pulse_k + 1) req[1] = 1'b0;
            if (!hang && k == d) lcd_available = 1'b0;
            if (!hang && k == d + h) lcd_available = 1'b1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_enable"}, lcd_enable_writing, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_data"}, lcd_data, 0);
        chk({tag, "_cd"}, lcd_select_cd, 0);
        chk({tag, "_terr"}, timeout_err, 0);
    endtask

    initial begin
        rst = 1'b1; req = '0; req_data = '0; req_cd = '0; lcd_available = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0; last_m = NR - 1; te_m = 1'b0;

        // Single requester, character word
        req = 2'b01; req_data[0 +: DW] = 32'h48454C4C; req_cd[0] = 1'b1;
        run_txn(2, 10, 1'b0, 1'b1, -1);
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_ack", ack, 0);

        // Both requesting, four transactions alternating
        req = 2'b11; set_word(0); set_word(1);
        for (int t = 0; t < 4; t++) run_txn(int'($urandom_range(2, 5)), int'($urandom_range(1, 8)), 1'b0, 1'b0, -1);
        req = '0;

        // Writer not available: no grant until it is
        lcd_available = 1'b0; req = 2'b01; set_word(0);
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("unavail_ack", ack, 0);
            chk("unavail_busy", busy, 0);
        end
        lcd_available = 1'b1;
        run_txn(3, 2, 1'b0, 1'b1, -1);

        // Writer never responds: timeout abort, then normal service continues
        req = 2'b01; set_word(0);
        run_txn(0, 0, 1'b1, 1'b1, -1);
        req = 2'b10; set_word(1);
        run_txn(3, 4, 1'b0, 1'b1, -1);

        // req[1] glitch while requester 0 is in WAIT_DONE is never granted
        req = 2'b01; set_word(0);
        run_txn(2, 6, 1'b0, 1'b1, 4);
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("glitch_ack", ack, 0);
        end

        // Reset in WAIT_DONE
        req = 2'b11; set_word(0); set_word(1);
        tick();
        chk("pre_rst_ack", ack, NR'(1) << rr(2'b11, last_m));
        tick();
        tick();
        lcd_available = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk_all_zero("mid_rst");
        rst = 1'b0; lcd_available = 1'b1; last_m = NR - 1; te_m = 1'b0;
        chk("rst_first_pick", rr(req, last_m), 0);
        run_txn(2, 3, 1'b0, 1'b0, -1);
        run_txn(2, 3, 1'b0, 1'b0, -1);

        // Random mixes
        for (int t = 0; t < 8; t++) begin
            req = NR'($urandom_range(1, 3));
            set_word(0); set_word(1);
            run_txn(int'($urandom_range(2, 6)), int'($urandom_range(1, 9)), 1'b0, 1'($urandom_range(0, 1)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
